mem_arbiter: RTL

Two-port round-robin arbiter that shares one `memory_unit` data port between two requesters, e.g. core load/store stage (port 0) and a DMA/debug master (port 1). It serialises one transaction at a time:
- captures a winning request;
- issues it to the memory unit as a single-cycle load/store command;
- waits for the unit's `valid`;
- returns the data to the winner as a one-cycle response.

---
 rtl/mem_arbiter_if.sv | 61 ++++++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_arbiter_if : two requester ports plus the memory_unit data port
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20
);
   // requester port 0
   logic                    req0_load;
   logic                    req0_store;
   logic [ADDRESS_BITS-1:0] req0_address;
   logic [DATA_WIDTH-1:0]   req0_store_data;
   logic                    req0_accept;
   logic                    req0_valid;

   // requester port 1
   logic                    req1_load;
   logic                    req1_store;
   logic [ADDRESS_BITS-1:0] req1_address;
   logic [DATA_WIDTH-1:0]   req1_store_data;
   logic                    req1_accept;
   logic                    req1_valid;

   // shared response
   logic [DATA_WIDTH-1:0]   resp_data;
   logic [ADDRESS_BITS-1:0] resp_addr;
   logic                    resp_error;

   // memory_unit side
   logic                    mem_load;
   logic                    mem_store;
   logic [ADDRESS_BITS-1:0] mem_address;
   logic [DATA_WIDTH-1:0]   mem_store_data;
   logic                    mem_ready;
   logic                    mem_valid;
   logic [DATA_WIDTH-1:0]   mem_load_data;
   logic [ADDRESS_BITS-1:0] mem_data_addr;

   modport slave (
      input  req0_load, req0_store, req0_address, req0_store_data,
      input  req1_load, req1_store, req1_address, req1_store_data,
      input  mem_ready, mem_valid, mem_load_data, mem_data_addr,
      output req0_accept, req0_valid, req1_accept, req1_valid,
      output resp_data, resp_addr, resp_error,
      output mem_load, mem_store, mem_address, mem_store_data
   );

   modport master (
      output req0_load, req0_store, req0_address, req0_store_data,
      output req1_load, req1_store, req1_address, req1_store_data,
      output mem_ready, mem_valid, mem_load_data, mem_data_addr,
      input  req0_accept, req0_valid, req1_accept, req1_valid,
      input  resp_data, resp_addr, resp_error,
      input  mem_load, mem_store, mem_address, mem_store_data
   );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter : two-port round-robin arbiter in front of one memory_unit port.
// Optional WAIT timeout enabled by defining MEM_ARB_TIMEOUT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_BITS   = 20,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  wire logic    clock,
   input  wire logic    reset,
   mem_arbiter_if.slave bus
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_issue = 2'd1;
   localparam logic [1:0] c_st_wait  = 2'd2;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
      $error("mem_arbiter: TIMEOUT_CYCLES must lie in 1..255");
   end

   logic [1:0]              r_state;
   logic [1:0]              w_next_state;

   logic                    w_req0;
   logic                    w_req1;
   logic                    w_start;
   logic                    w_pick;
   logic                    w_mem_done;
   logic                    w_timeout;

   logic                    r_last_grant;
   logic                    r_winner;
   logic                    r_is_store;
   logic [ADDRESS_BITS-1:0] r_mem_address;
   logic [DATA_WIDTH-1:0]   r_mem_store_data;

   logic                    r_valid0;
   logic                    r_valid1;
   logic [DATA_WIDTH-1:0]   r_resp_data;
   logic [ADDRESS_BITS-1:0] r_resp_addr;
   logic                    r_resp_error;

   assign w_req0     = bus.req0_load | bus.req0_store;
   assign w_req1     = bus.req1_load | bus.req1_store;
   assign w_start    = (r_state == c_st_idle) && bus.mem_ready && (w_req0 || w_req1);
   // On a tie the port that was not granted last time wins.
   assign w_pick     = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
   assign w_mem_done = (r_state == c_st_wait) && bus.mem_valid;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_wait_count;

   // Fires during the TIMEOUT_CYCLES-th consecutive WAIT cycle without valid.
   assign w_timeout = (r_state == c_st_wait) && !bus.mem_valid &&
                      (r_wait_count == c_timeout_last);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wait_count <= 8'd0;
      end else if (r_state == c_st_issue) begin
         r_wait_count <= 8'd0;
      end else if ((r_state == c_st_wait) && !bus.mem_valid) begin
         r_wait_count <= r_wait_count + 8'd1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle:  if (w_start) w_next_state = c_st_issue;
         c_st_issue: w_next_state = c_st_wait;
         c_st_wait:  if (w_mem_done || w_timeout) w_next_state = c_st_idle;
         default:    w_next_state = c_st_idle;
      endcase
   end

   always_comb begin
      bus.req0_accept = 1'b0;
      bus.req1_accept = 1'b0;
      bus.mem_load    = 1'b0;
      bus.mem_store   = 1'b0;
      if (r_state == c_st_issue) begin
         bus.req0_accept = ~r_winner;
         bus.req1_accept = r_winner;
         bus.mem_load    = ~r_is_store;
         bus.mem_store   = r_is_store;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_last_grant     <= 1'b1;
         r_winner         <= 1'b0;
         r_is_store       <= 1'b0;
         r_mem_address    <= '0;
         r_mem_store_data <= '0;
         r_valid0         <= 1'b0;
         r_valid1         <= 1'b0;
         r_resp_data      <= '0;
         r_resp_addr      <= '0;
         r_resp_error     <= 1'b0;
      end else begin
         r_valid0 <= 1'b0;
         r_valid1 <= 1'b0;

         // A store flag wins over a simultaneous load flag.
         if (w_start) begin
            r_winner     <= w_pick;
            r_last_grant <= w_pick;
            if (w_pick) begin
               r_is_store       <= bus.req1_store;
               r_mem_address    <= bus.req1_address;
               r_mem_store_data <= bus.req1_store_data;
            end else begin
               r_is_store       <= bus.req0_store;
               r_mem_address    <= bus.req0_address;
               r_mem_store_data <= bus.req0_store_data;
            end
         end

         if (w_mem_done) begin
            r_resp_data  <= bus.mem_load_data;
            r_resp_addr  <= bus.mem_data_addr;
            r_resp_error <= 1'b0;
            r_valid0     <= ~r_winner;
            r_valid1     <= r_winner;
         end else if (w_timeout) begin
            r_resp_data  <= '0;
            r_resp_addr  <= r_mem_address;
            r_resp_error <= 1'b1;
            r_valid0     <= ~r_winner;
            r_valid1     <= r_winner;
         end
      end
   end

   assign bus.mem_address    = r_mem_address;
   assign bus.mem_store_data = r_mem_store_data;
   assign bus.req0_valid     = r_valid0;
   assign bus.req1_valid     = r_valid1;
   assign bus.resp_data      = r_resp_data;
   assign bus.resp_addr      = r_resp_addr;
`ifdef MEM_ARB_TIMEOUT_EN
   assign bus.resp_error     = r_resp_error;
`else
   assign bus.resp_error     = 1'b0;
`endif

endmodule

`default_nettype wire
